// File: rtl/counter_pkg.sv
// Shared types and the active-low seven-segment decode table for the multi-digit counter.
package counter_pkg;

  typedef logic [3:0] digit_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic seg_t seg_decode(input digit_t d);
    seg_t s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioning: 2-flop synchroniser, stability-timer debounce and a registered
// one-cycle pulse on the rising edge of the accepted level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int TW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [TW-1:0] timer_q, timer_d;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          pulse_q, pulse_d;

  // The timer only runs while the synchronised level disagrees with the accepted one,
  // so any bounce back to the accepted level restarts the stability window.
  always_comb begin
    timer_d = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (timer_q == TIMER_LAST) begin
        level_d = sync_q[1];
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
    pulse_d = level_q & ~level_dly_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q      <= '0;
      timer_q     <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], btn_i};
      timer_q     <= timer_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      pulse_q     <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/multi_digit_counter.sv
// N-digit up/down counter with debounced buttons and a scanned seven-segment display.
// Define COUNTER_BCD_EN for decimal digits (0-9 per digit); otherwise the count is plain hex.
module multi_digit_counter
  import counter_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SCAN_CYCLES     = 100000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  btn_inc,
  input  logic                  btn_dec,
  input  logic                  clr,
  input  logic                  en,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [6:0]            segment,
  output logic [DIGITS-1:0]     anode
);

  localparam int W   = 4 * DIGITS;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int STW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  logic inc_p, dec_p;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_db (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .btn_i  (btn_inc),
    .pulse_o(inc_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec_db (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .btn_i  (btn_dec),
    .pulse_o(dec_p)
  );

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] inc_val, dec_val;
  logic         inc_wrap, dec_wrap;
  logic         wrap_q, wrap_d;
  logic         inc_act, dec_act;

`ifdef COUNTER_BCD_EN
  // Decimal ripple: each digit rolls 9->0 (or 0->9) and passes the carry/borrow upward.
  always_comb begin
    logic carry, borrow;
    inc_val = count_q;
    dec_val = count_q;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    inc_wrap = carry;
    dec_wrap = borrow;
  end
`else
  always_comb begin
    inc_val  = count_q + W'(1);
    dec_val  = count_q - W'(1);
    inc_wrap = &count_q;
    dec_wrap = ~|count_q;
  end
`endif

  // clr wins outright; simultaneous inc and dec pulses cancel.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    inc_act = en & inc_p & ~dec_p;
    dec_act = en & dec_p & ~inc_p;
    if (clr) begin
      count_d = '0;
    end else if (inc_act) begin
      count_d = inc_val;
      wrap_d  = inc_wrap;
    end else if (dec_act) begin
      count_d = dec_val;
      wrap_d  = dec_wrap;
    end
  end

  logic [STW-1:0]    scan_tmr_q, scan_tmr_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0] anode_q, anode_d;
  seg_t              segment_q, segment_d;
  digit_t            cur_digit;

  // Anode and segment are computed from the next index so both flip on the same edge.
  always_comb begin
    scan_tmr_d = scan_tmr_q + STW'(1);
    idx_d      = idx_q;
    if (scan_tmr_q == STW'(SCAN_CYCLES - 1)) begin
      scan_tmr_d = '0;
      if (idx_q == IW'(DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
    cur_digit = '0;
    anode_d   = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IW'(i)) begin
        cur_digit  = count_q[4*i +: 4];
        anode_d[i] = 1'b0;
      end
    end
    segment_d = seg_decode(cur_digit);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      scan_tmr_q <= '0;
      idx_q      <= '0;
      anode_q    <= {{(DIGITS-1){1'b1}}, 1'b0};
      segment_q  <= seg_decode(4'h0);
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      scan_tmr_q <= scan_tmr_d;
      idx_q      <= idx_d;
      anode_q    <= anode_d;
      segment_q  <= segment_d;
    end
  end

  assign count   = count_q;
  assign wrap    = wrap_q;
  assign segment = segment_q;
  assign anode   = anode_q;

endmodule

// File: tb/tb_multi_digit_counter.sv
// Directed bench for multi_digit_counter: DIGITS=2, DEBOUNCE_CYCLES=4, SCAN_CYCLES=3.
module tb_multi_digit_counter;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       btn_inc, btn_dec, clr, en;
  logic [7:0] count;
  logic       wrap;
  logic [6:0] segment;
  logic [1:0] anode;

  int n_tests = 0;
  int n_fail  = 0;
  int wrap_cnt = 0;
  int w0;

`ifdef COUNTER_BCD_EN
  localparam logic [7:0] MAXV = 8'h99;
  localparam int         N37  = 37;
`else
  localparam logic [7:0] MAXV = 8'hFF;
  localparam int         N37  = 55;
`endif

  multi_digit_counter #(
    .DIGITS(2),
    .DEBOUNCE_CYCLES(4),
    .SCAN_CYCLES(3)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .btn_inc(btn_inc),
    .btn_dec(btn_dec),
    .clr    (clr),
    .en     (en),
    .count  (count),
    .wrap   (wrap),
    .segment(segment),
    .anode  (anode)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (wrap === 1'b1) wrap_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic press(input logic i, input logic d);
    btn_inc = i;
    btn_dec = d;
    tick(10);
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    tick(10);
  endtask

  task automatic press_inc_n(input int n);
    for (int k = 0; k < n; k++) press(1'b1, 1'b0);
  endtask

  task automatic scan_check(input logic [6:0] s0, input logic [6:0] s1);
    int guard;
    guard = 0;
    while (anode !== 2'b01 && guard < 10) begin tick(1); guard++; end
    while (anode !== 2'b10 && guard < 20) begin tick(1); guard++; end
    check_eq("scan_sync", anode, 2'b10);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 3; c++) begin
        check_eq("scan_anode0", anode, 2'b10);
        check_eq("scan_seg0", segment, s0);
        tick(1);
      end
      for (int c = 0; c < 3; c++) begin
        check_eq("scan_anode1", anode, 2'b01);
        check_eq("scan_seg1", segment, s1);
        tick(1);
      end
    end
  endtask

  initial begin
    RST_N = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; clr = 1'b0; en = 1'b1;
    tick(3);
    check_eq("rst_count", count, 8'h00);
    check_eq("rst_wrap", wrap, 1'b0);
    check_eq("rst_anode", anode, 2'b10);
    check_eq("rst_segment", segment, 7'b1000000);
    RST_N = 1'b1;
    tick(2);

    // Bouncing press: only the final stable hold is accepted, 8 cycles after its edge.
    for (int k = 0; k < 5; k++) begin
      btn_inc = 1'b1; tick(2);
      btn_inc = 1'b0; tick(2);
    end
    check_eq("bounce_no_inc", count, 8'h00);
    btn_inc = 1'b1;
    tick(7);
    check_eq("latency_minus1", count, 8'h00);
    tick(1);
    check_eq("latency_inc", count, 8'h01);
    tick(2);
    btn_inc = 1'b0;
    tick(20);
    check_eq("release_no_change", count, 8'h01);

    w0 = wrap_cnt;
    press_inc_n(N37 - 1);
    check_eq("count_37", count, 8'h37);
    check_eq("no_wrap_37", wrap_cnt - w0, 0);
    scan_check(7'b1111000, 7'b0110000);

    RST_N = 1'b0;
    #1;
    check_eq("async_rst_count", count, 8'h00);
    check_eq("async_rst_anode", anode, 2'b10);
    check_eq("async_rst_segment", segment, 7'b1000000);
    tick(1);
    RST_N = 1'b1;
    tick(1);

`ifdef COUNTER_BCD_EN
    press_inc_n(9);
    check_eq("bcd_09", count, 8'h09);
    press(1'b1, 1'b0);
    check_eq("bcd_09_inc", count, 8'h10);
    press(1'b0, 1'b1);
    check_eq("bcd_10_dec", count, 8'h09);
    clr = 1'b1; tick(1); clr = 1'b0; tick(1);
    w0 = wrap_cnt;
    press(1'b0, 1'b1);
    check_eq("bcd_00_dec", count, 8'h99);
    check_eq("bcd_dec_wrap", wrap_cnt - w0, 1);
    w0 = wrap_cnt;
    press(1'b1, 1'b0);
    check_eq("bcd_99_inc", count, 8'h00);
    check_eq("bcd_inc_wrap", wrap_cnt - w0, 1);
    press(1'b0, 1'b1);
`else
    w0 = wrap_cnt;
    press(1'b0, 1'b1);
    check_eq("hex_00_dec", count, 8'hFF);
    check_eq("hex_dec_wrap", wrap_cnt - w0, 1);
    w0 = wrap_cnt;
    btn_inc = 1'b1;
    tick(8);
    check_eq("hex_ff_inc", count, 8'h00);
    check_eq("hex_wrap_high", wrap, 1'b1);
    tick(1);
    check_eq("hex_wrap_low", wrap, 1'b0);
    tick(1);
    btn_inc = 1'b0;
    tick(10);
    check_eq("hex_inc_wrap_cnt", wrap_cnt - w0, 1);
    w0 = wrap_cnt;
    press(1'b0, 1'b1);
    check_eq("hex_00_dec2", count, 8'hFF);
    check_eq("hex_dec_wrap2", wrap_cnt - w0, 1);
`endif

    // Count sits at max here.
    w0 = wrap_cnt;
    press(1'b1, 1'b1);
    check_eq("both_press", count, MAXV);
    check_eq("both_no_wrap", wrap_cnt - w0, 0);
    clr = 1'b1;
    tick(1);
    check_eq("clr_next_cycle", count, 8'h00);
    press(1'b1, 1'b0);
    check_eq("clr_over_inc", count, 8'h00);
    clr = 1'b0;
    tick(1);
    check_eq("clr_no_wrap", wrap_cnt - w0, 0);
    en = 1'b0;
    press(1'b1, 1'b0);
    check_eq("en_off_inc", count, 8'h00);
    press(1'b0, 1'b1);
    check_eq("en_off_dec", count, 8'h00);
    check_eq("en_off_no_wrap", wrap_cnt - w0, 0);
    en = 1'b1;

`ifndef COUNTER_BCD_EN
    press_inc_n(8'h5A);
    check_eq("count_5a", count, 8'h5A);
    scan_check(7'b0001000, 7'b0010010);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
